nios2_mul_cell_arbiter: RTL and testbench
=========================================

# nios2_mul_cell_arbiter

Two-requester round-robin arbiter and pipeline sequencer for the shared 32×32 multiplier cell. It accepts multiply operations over valid/ready handshakes and drives the cell's operand and sign inputs. It also drives the cell's two stage enables: the input-register enable and the output-register enable. Results are returned tagged with the requester ID, with full backpressure. It sits between the CPU execute-stage multiply path and a second client (custom-instruction/DSP engine) that share one hard-multiplier cell.

## Interface
- `DATA_W`, 32, operand and result width.
- `LATENCY`, 2, cell stages: input register plus output register. Fixed; the only supported value.
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `req0_valid` / `req1_valid` in 1: operation request.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in DATA_W: operands.
- `req0_signed_a`, `req0_signed_b` / `req1_signed_a`, `req1_signed_b` in 1: operand signedness.
- `mul_dataa`, `mul_datab` out DATA_W: to cell.
- `mul_signa`, `mul_signb` out 1: to cell.
- `mul_en_in` out 1: cell input-register enable.
- `mul_en_out` out 1: cell output-register enable.
- `mul_result` in DATA_W: cell registered result, the low DATA_W bits of the product.
- `rsp_valid` out 1: result available.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_data` out DATA_W: equals `mul_result`.
- `rsp_ready` in 1: consumer accepts the response.
- `busy` out 1: any operation in flight (`v1 | v2`).

## Operation
- State:
  - `v1`/`id1`: operation held in the cell input stage.
  - `v2`/`id2`: operation held in the cell output stage. `rsp_valid` = `v2` and `rsp_id` = `id2`.
  - `last`: the last granted requester.
- Advance: `adv = ~v2 | rsp_ready`.
  - `mul_en_in` = `mul_en_out` = `adv`.
  - When `adv`=0 the whole pipe freezes: cell registers hold, `v1`/`v2`/ids hold, and both readies are 0.
- Arbitration (combinational): `grant` = the only valid requester. If both are valid, `grant` = `~last`.
- `reqN_ready = adv & (grant==N) & reqN_valid`. `accept = adv & any valid`.
- Operand mux: `mul_data*` and `mul_sign*` always follow the granted requester. If neither is valid they follow requester 0; the value is don't-care because `v1`=0.
- On each `adv` edge:
  - `v2<=v1`, `id2<=id1`.
  - `v1<=accept`, `id1<=grant`.
  - `last<=grant` when `accept`.
- Requesters must hold `valid` and operands stable until `ready`. Responses must be held until `rsp_ready`.
- Arithmetic: the result is the low DATA_W bits of the product. The sign flags select the signed/unsigned interpretation; the cell computes the product and this block does not.

## Timing
- Reset values (synchronous, while `reset_n`=0):
  - State: `v1`=`v2`=0, `id1`=`id2`=0, `last`=1, so requester 0 wins first contention.
  - Outputs: `rsp_valid`=0, `rsp_id`=0, `busy`=0, `mul_en_in`=`mul_en_out`=1 (since `v2`=0, `adv`=1), both readies 0.
- Reset mid-operation: in-flight operations are discarded and no response is produced. The first accept is possible in the cycle `reset_n` rises.
- Latency: an operation accepted in cycle N gives `rsp_valid`=1 in cycle N+2 when unstalled.
- Throughput: one operation per cycle.
- Back-to-back from the same requester is allowed when the other requester is idle.
- Simultaneous `rsp_ready`=1 with `v2`=1 and a new accept: the response retires, the pipe shifts, and the new operation is accepted in the same cycle.
- Stall of K cycles: the response is held unchanged and later operations are delayed by exactly K cycles.

## Structure
- Package `nios2_mul_arb_pkg`:
  - `MUL_LATENCY`=2.
  - `MUL_ID_W`=1.
  - `typedef mul_req_t` {a, b, signed_a, signed_b}.
- Sub-module `rr_arbiter2`: two-way round-robin with a `last` register and an `update` input. Everything else is inline.

## Test plan
- Single op, idle: `req0` a=7, b=6, both unsigned, accepted cycle N. Required: `rsp_valid` cycle N+2 with id=0, data=42.
- Signed: `req1` a=0xFFFFFFFE (−2), b=3, both signed. Required: data=0xFFFFFFFA (−6), id=1.
- Contention: both valid for 4 cycles after reset. Required: grants 0,1,0,1 and responses in the same order two cycles later.
- Backpressure: `rsp_ready`=0 for 3 cycles with `v2`=1 and `v1`=1. Required: both readies 0, the response is held, and no ops are lost. Both responses follow in order after release.
- Reset mid-flight: `reset_n`=0 for one cycle with two ops in flight. Required: `rsp_valid`=0 and `busy`=0 next cycle; no stale response appears; the next grant goes to requester 0.
- Streaming: `req0` issues 100 back-to-back ops with `rsp_ready`=1. Required: 100 responses on consecutive cycles, each matching a reference model.

Source files
------------

// File: rtl/nios2_mul_arb_pkg.sv
// Shared types and constants for the multiplier-cell arbiter.
//   MUL_LATENCY : cell pipeline depth (input register + output register)
//   MUL_ID_W    : width of the requester tag carried down the pipe
//   MUL_DATA_W  : operand / result width
//   mul_req_t   : one multiply request as presented by a requester
package nios2_mul_arb_pkg;

  localparam int MUL_LATENCY = 2;
  localparam int MUL_ID_W    = 1;
  localparam int MUL_DATA_W  = 32;

  typedef struct packed {
    logic [MUL_DATA_W-1:0] a;
    logic [MUL_DATA_W-1:0] b;
    logic                  signed_a;
    logic                  signed_b;
  } mul_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset_n   : clock, synchronous active-low reset
//   valid0/valid1  : requester valids
//   update         : a grant was consumed this cycle; remember it
//   grant          : selected requester (0 when nobody is valid)
// After reset 'last' is 1 so requester 0 wins the first contention.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset_n,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  output logic grant
);

  logic last;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant;
    end
  end

  // Sole valid requester wins; on contention the one not granted last wins.
  always_comb begin
    if (valid0 && valid1) begin
      grant = ~last;
    end else begin
      grant = valid1;
    end
  end

endmodule

// File: rtl/nios2_mul_cell_arbiter.sv
// Round-robin arbiter and pipeline sequencer for a shared 2-stage 32x32
// multiplier cell.
//   clk, reset_n                  : clock, synchronous active-low reset
//   reqN_valid / reqN_ready       : request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_signed_* : operands and signedness
//   mul_dataa/b, mul_signa/b      : operands to the cell (granted requester)
//   mul_en_in / mul_en_out        : cell input / output register enables
//   mul_result                    : cell registered result (low DATA_W bits)
//   rsp_valid/rsp_id/rsp_data     : tagged response, held until rsp_ready
//   busy                          : an operation is in flight
// v1/id1 shadow the cell input stage, v2/id2 the output stage. When a
// response is stalled the whole pipe (cell registers included) freezes.
module nios2_mul_cell_arbiter
  import nios2_mul_arb_pkg::*;
#(
  parameter int DATA_W  = MUL_DATA_W,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_signed_a,
  input  logic              req0_signed_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_signed_a,
  input  logic              req1_signed_b,
  output logic [DATA_W-1:0] mul_dataa,
  output logic [DATA_W-1:0] mul_datab,
  output logic              mul_signa,
  output logic              mul_signb,
  output logic              mul_en_in,
  output logic              mul_en_out,
  input  logic [DATA_W-1:0] mul_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy
);

  // The sequencer tracks exactly two cell stages.
  if (LATENCY != MUL_LATENCY) begin : g_bad_latency
    $error("nios2_mul_cell_arbiter supports LATENCY == 2 only");
  end

  logic                v1;
  logic                v2;
  logic [MUL_ID_W-1:0] id1;
  logic [MUL_ID_W-1:0] id2;
  logic                adv;
  logic                any_valid;
  logic                accept;
  logic                grant;
  mul_req_t            req0;
  mul_req_t            req1;
  mul_req_t            sel;

  // The pipe moves whenever the output stage is empty or being drained.
  assign adv       = ~v2 | rsp_ready;
  assign any_valid = req0_valid | req1_valid;
  // Holding off accepts during reset keeps both readies low while reset_n=0.
  assign accept    = adv & any_valid & reset_n;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .update  (accept),
    .grant   (grant)
  );

  assign req0_ready = accept & ~grant & req0_valid;
  assign req1_ready = accept &  grant & req1_valid;

  assign req0 = '{a: req0_a, b: req0_b, signed_a: req0_signed_a, signed_b: req0_signed_b};
  assign req1 = '{a: req1_a, b: req1_b, signed_a: req1_signed_a, signed_b: req1_signed_b};

  // NOTE: every variable assigned in always_comb gets a value on every path;
  // the default-first form here keeps the mux from inferring a latch.
  always_comb begin
    sel = req0;
    if (grant) begin
      sel = req1;
    end
  end

  assign mul_dataa  = sel.a;
  assign mul_datab  = sel.b;
  assign mul_signa  = sel.signed_a;
  assign mul_signb  = sel.signed_b;
  assign mul_en_in  = adv;
  assign mul_en_out = adv;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      id1 <= '0;
      id2 <= '0;
    end else if (adv) begin
      v2  <= v1;
      id2 <= id1;
      v1  <= accept;
      id1 <= grant;
    end
  end

  assign rsp_valid = v2;
  assign rsp_id    = id2;
  assign rsp_data  = mul_result;
  assign busy      = v1 | v2;

endmodule

// File: tb/tb_nios2_mul_cell_arbiter.sv
// Directed self-checking bench for nios2_mul_cell_arbiter. A behavioural
// two-stage multiplier cell closes the loop on the cell ports.
module tb_nios2_mul_cell_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_signed_a = 1'b0, req0_signed_b = 1'b0;
  logic         req1_signed_a = 1'b0, req1_signed_b = 1'b0;
  logic [W-1:0] mul_dataa, mul_datab;
  logic         mul_signa, mul_signb, mul_en_in, mul_en_out;
  logic [W-1:0] mul_result;
  logic         rsp_valid, rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_ready = 1'b1;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios2_mul_cell_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_signed_a (req0_signed_a),
    .req0_signed_b (req0_signed_b),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_signed_a (req1_signed_a),
    .req1_signed_b (req1_signed_b),
    .mul_dataa     (mul_dataa),
    .mul_datab     (mul_datab),
    .mul_signa     (mul_signa),
    .mul_signb     (mul_signb),
    .mul_en_in     (mul_en_in),
    .mul_en_out    (mul_en_out),
    .mul_result    (mul_result),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .busy          (busy)
  );

  // Behavioural cell: 64-bit sign/zero-extended product, low half registered.
  logic [W-1:0] cell_a, cell_b;
  logic         cell_sa, cell_sb;
  logic [63:0]  cell_ext_a, cell_ext_b, cell_prod;

  always_comb begin
    cell_ext_a = cell_sa ? {{32{cell_a[W-1]}}, cell_a} : {32'b0, cell_a};
    cell_ext_b = cell_sb ? {{32{cell_b[W-1]}}, cell_b} : {32'b0, cell_b};
    cell_prod  = cell_ext_a * cell_ext_b;
  end

  always @(posedge clk) begin
    if (mul_en_in) begin
      cell_a  <= mul_dataa;
      cell_b  <= mul_datab;
      cell_sa <= mul_signa;
      cell_sb <= mul_signb;
    end
    if (mul_en_out) mul_result <= cell_prod[W-1:0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sa, input logic sb);
    req0_valid = v; req0_a = a; req0_b = b; req0_signed_a = sa; req0_signed_b = sb;
  endtask

  task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sa, input logic sb);
    req1_valid = v; req1_a = a; req1_b = b; req1_signed_a = sa; req1_signed_b = sb;
  endtask

  logic [W-1:0] s_a [100];
  logic [W-1:0] s_b [100];
  logic [W-1:0] s_exp [100];

  initial begin
    // ---- reset state (requests asserted to show readies stay low) ----
    set0(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    set1(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) step();
    mid();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_en_in", mul_en_in, 1);
    check("rst_en_out", mul_en_out, 1);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    step();

    // ---- single unsigned op from req0: 7*6 ----
    reset_n = 1'b1;
    set0(1'b1, 32'd7, 32'd6, 1'b0, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    mid();
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    check("t1_dataa", mul_dataa, 7);
    step();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    mid();
    check("t1_busy", busy, 1);
    check("t1_early_valid", rsp_valid, 0);
    step();
    mid();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_data", rsp_data, 42);
    step();
    mid();
    check("t1_drained", rsp_valid, 0);
    check("t1_idle", busy, 0);

    // ---- signed op from req1: -2 * 3 ----
    set1(1'b1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    mid();
    check("t2_ready1", req1_ready, 1);
    check("t2_signa", mul_signa, 1);
    check("t2_dataa", mul_dataa, 32'hFFFF_FFFE);
    step();
    set1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    mid();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_id", rsp_id, 1);
    check("t2_rsp_data", rsp_data, 32'hFFFF_FFFA);
    step();

    // ---- contention after reset: grants 0,1,0,1 ----
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set0(1'b1, 32'd2, 32'd3, 1'b0, 1'b0);
    set1(1'b1, 32'd4, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        set0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        set1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      end
      mid();
      if (i < 4) begin
        check($sformatf("t3_ready0_%0d", i), req0_ready, (i % 2 == 0));
        check($sformatf("t3_ready1_%0d", i), req1_ready, (i % 2 == 1));
      end
      if (i >= 2) begin
        check($sformatf("t3_rsp_valid_%0d", i), rsp_valid, 1);
        check($sformatf("t3_rsp_id_%0d", i), rsp_id, (i % 2));
        check($sformatf("t3_rsp_data_%0d", i), rsp_data, (i % 2 == 0) ? 6 : 20);
      end
      step();
    end

    // ---- backpressure: 3-cycle stall with both stages full ----
    rsp_ready = 1'b0;
    set0(1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    mid();
    check("t4_acc_a", req0_ready, 1);
    step();
    set0(1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    mid();
    check("t4_acc_b", req0_ready, 1);
    step();
    set0(1'b1, 32'd7, 32'd7, 1'b0, 1'b0);
    set1(1'b1, 32'd2, 32'd8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mid();
      check($sformatf("t4_stall_ready0_%0d", k), req0_ready, 0);
      check($sformatf("t4_stall_ready1_%0d", k), req1_ready, 0);
      check($sformatf("t4_stall_en_%0d", k), mul_en_in, 0);
      check($sformatf("t4_stall_valid_%0d", k), rsp_valid, 1);
      check($sformatf("t4_stall_data_%0d", k), rsp_data, 9);
      step();
    end
    rsp_ready = 1'b1;
    mid();
    check("t4_rel_data", rsp_data, 9);
    check("t4_rel_ready1", req1_ready, 1);
    check("t4_rel_ready0", req0_ready, 0);
    step();
    set1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    mid();
    check("t4_r2_valid", rsp_valid, 1);
    check("t4_r2_data", rsp_data, 25);
    check("t4_r2_ready0", req0_ready, 1);
    step();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    mid();
    check("t4_r3_id", rsp_id, 1);
    check("t4_r3_data", rsp_data, 16);
    step();
    mid();
    check("t4_r4_id", rsp_id, 0);
    check("t4_r4_data", rsp_data, 49);
    step();
    mid();
    check("t4_idle", busy, 0);

    // ---- reset with two ops from req0 in flight ----
    set0(1'b1, 32'd11, 32'd11, 1'b0, 1'b0);
    step();
    set0(1'b1, 32'd12, 32'd12, 1'b0, 1'b0);
    step();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    mid();
    check("t5_pre_busy", busy, 1);
    step();
    reset_n = 1'b1;
    set0(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    set1(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    mid();
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_ready0", req0_ready, 1);
    check("t5_ready1", req1_ready, 0);
    step();
    set0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    mid();
    check("t5_no_stale", rsp_valid, 0);
    step();
    mid();
    check("t5_new_valid", rsp_valid, 1);
    check("t5_new_id", rsp_id, 0);
    check("t5_new_data", rsp_data, 81);
    step();
    mid();
    check("t5_idle", rsp_valid, 0);

    // ---- 100 back-to-back ops from req0 ----
    for (int i = 0; i < 100; i++) begin
      s_a[i]   = i * 32'h9E37_79B9 + 32'h1234;
      s_b[i]   = 32'hFFFF_0000 ^ (i * 7);
      s_exp[i] = s_a[i] * s_b[i];
    end
    for (int i = 0; i < 102; i++) begin
      if (i < 100) set0(1'b1, s_a[i], s_b[i], i[0], i[1]);
      else         set0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      mid();
      if (i < 100) check($sformatf("t6_ready_%0d", i), req0_ready, 1);
      if (i >= 2) begin
        check($sformatf("t6_valid_%0d", i - 2), rsp_valid, 1);
        check($sformatf("t6_data_%0d", i - 2), rsp_data, s_exp[i - 2]);
      end
      step();
    end
    mid();
    check("t6_done", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
